// File: rtl/controller_pipe_gen.sv
// Purpose: MIPS-style main/ALU decoder with E, M1..Mn and W control pipeline plus retired-instruction counter.
// Latency: decode/pcsrcD combinational; D->E 1, E->M1 1, M1->Mn MEM_STAGES-1, Mn->W 1 cycle.
// Backpressure: stallE holds E and injects a bubble into M1; M and W stages always advance.
module controller_pipe_gen #(
    parameter int MEM_STAGES = 1,
    parameter int ALUCTL_W   = 3,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                equalD,
    input  logic                stallE,
    input  logic                flushE,
    output logic [1:0]          pcsrcD,
    output logic                branchD,
    output logic                jumpD,
    output logic                illegalD,
    output logic                alusrcE,
    output logic                regdstE,
    output logic                regwriteE,
    output logic                memtoregE,
    output logic [ALUCTL_W-1:0] alucontrolE,
    output logic                memwriteM,
    output logic                memreadM,
    output logic                regwriteM,
    output logic                memtoregM,
    output logic                regwriteW,
    output logic                memtoregW,
    output logic [CNT_W-1:0]    retired
);

    typedef struct packed {
        logic       vld;
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic [2:0] alu;
    } ctl_e_t;

    typedef struct packed {
        logic vld;
        logic regwrite;
        logic memtoreg;
        logic memread;
        logic memwrite;
    } ctl_m_t;

    typedef struct packed {
        logic vld;
        logic regwrite;
        logic memtoreg;
    } ctl_w_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    ctl_e_t     dec_ctl;
    logic [1:0] aluop;
    logic       legal;
    logic       dec_branch;
    logic       dec_jump;
    logic       is_beq;
    logic       is_bne;

    // ---------------- decode ----------------
    always_comb begin
        dec_ctl    = '0;
        aluop      = 2'b00;
        legal      = 1'b1;
        dec_branch = 1'b0;
        dec_jump   = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec_ctl.regwrite = 1'b1;
                dec_ctl.regdst   = 1'b1;
                aluop            = 2'b10;
            end
            OP_LW: begin
                dec_ctl.regwrite = 1'b1;
                dec_ctl.alusrc   = 1'b1;
                dec_ctl.memtoreg = 1'b1;
                dec_ctl.memread  = 1'b1;
            end
            OP_SW: begin
                dec_ctl.alusrc   = 1'b1;
                dec_ctl.memwrite = 1'b1;
            end
            OP_BEQ: begin
                dec_branch = 1'b1;
                is_beq     = 1'b1;
                aluop      = 2'b01;
            end
            OP_BNE: begin
                dec_branch = 1'b1;
                is_bne     = 1'b1;
                aluop      = 2'b01;
            end
            OP_ADDI: begin
                dec_ctl.regwrite = 1'b1;
                dec_ctl.alusrc   = 1'b1;
            end
            OP_J:    dec_jump = 1'b1;
            default: legal = 1'b0;
        endcase

        case (aluop)
            2'b00: dec_ctl.alu = 3'b010;
            2'b01: dec_ctl.alu = 3'b110;
            default: begin
                case (funct)
                    6'b100000: dec_ctl.alu = 3'b010;
                    6'b100010: dec_ctl.alu = 3'b110;
                    6'b100100: dec_ctl.alu = 3'b000;
                    6'b100101: dec_ctl.alu = 3'b001;
                    6'b101010: dec_ctl.alu = 3'b111;
                    default: begin
                        dec_ctl.alu = 3'b000;
                        legal       = 1'b0;
                    end
                endcase
            end
        endcase

        // An illegal encoding must look exactly like a bubble downstream.
        if (!legal) begin
            dec_ctl    = '0;
            dec_branch = 1'b0;
            dec_jump   = 1'b0;
            is_beq     = 1'b0;
            is_bne     = 1'b0;
        end
        dec_ctl.vld = legal;
    end

    always_comb begin
        branchD  = dec_branch;
        jumpD    = dec_jump;
        illegalD = ~legal;
        if (dec_jump)
            pcsrcD = 2'b10;
        else if ((is_beq && equalD) || (is_bne && !equalD))
            pcsrcD = 2'b01;
        else
            pcsrcD = 2'b00;
    end

    // ---------------- pipeline registers ----------------
    ctl_e_t     e_q, e_d;
    ctl_m_t     m_q [MEM_STAGES];
    ctl_m_t     m_d [MEM_STAGES];
    ctl_w_t     w_q, w_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb begin
        if (stallE)
            e_d = e_q;
        else if (flushE)
            e_d = '0;
        else
            e_d = dec_ctl;

        // A held E must not be duplicated into M1.
        if (stallE)
            m_d[0] = '0;
        else
            m_d[0] = '{vld:      e_q.vld,
                       regwrite: e_q.regwrite,
                       memtoreg: e_q.memtoreg,
                       memread:  e_q.memread,
                       memwrite: e_q.memwrite};
        for (int i = 1; i < MEM_STAGES; i++)
            m_d[i] = m_q[i-1];

        w_d = '{vld:      m_q[MEM_STAGES-1].vld,
                regwrite: m_q[MEM_STAGES-1].regwrite,
                memtoreg: m_q[MEM_STAGES-1].memtoreg};

        retired_d = retired_q + CNT_W'(w_q.vld);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q       <= '0;
            w_q       <= '0;
            retired_q <= '0;
            for (int i = 0; i < MEM_STAGES; i++)
                m_q[i] <= '0;
        end else begin
            e_q       <= e_d;
            w_q       <= w_d;
            retired_q <= retired_d;
            for (int i = 0; i < MEM_STAGES; i++)
                m_q[i] <= m_d[i];
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        alusrcE     = e_q.alusrc;
        regdstE     = e_q.regdst;
        regwriteE   = e_q.regwrite;
        memtoregE   = e_q.memtoreg;
        alucontrolE = ALUCTL_W'(e_q.alu);
        memwriteM   = m_q[0].memwrite;
        memreadM    = m_q[0].memread;
        regwriteM   = m_q[MEM_STAGES-1].regwrite;
        memtoregM   = m_q[MEM_STAGES-1].memtoreg;
        regwriteW   = w_q.regwrite;
        memtoregW   = w_q.memtoreg;
        retired     = retired_q;
    end

endmodule
